// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID read checker.
package sysid_pkg;

    // Sequencing FSM states of the checker
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_ID,
        S_LAT_ID,
        S_REQ_TS,
        S_LAT_TS,
        S_DONE
    } state_t;

    // Word addresses on the sysid slave
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Width of the per-read waitrequest stall counter
    localparam int unsigned TO_CNT_W = 16;

endpackage

// File: rtl/avm_single_read.sv
// Single-word Avalon-MM read engine: issues one read on go, holds it through
// waitrequest stalls, returns data after a fixed latency, aborts on timeout.
module avm_single_read
    import sysid_pkg::*;
#(
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        go,
    input  logic        addr,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        timeout
);

    typedef logic [TO_CNT_W:0] cnt_ext_t;

    localparam logic [1:0] LP_LAT     = 2'(READ_LATENCY);
    localparam cnt_ext_t   LP_TIMEOUT = cnt_ext_t'(TIMEOUT_CYCLES);

    logic                r_read;
    logic                r_addr;
    logic [TO_CNT_W-1:0] r_stall;
    logic [1:0]          r_lat;

    logic                w_accept;
    logic                w_stall;
    cnt_ext_t            w_stall_next;

    // Handshake decode; timeout fires on the stall cycle that reaches the limit
    always_comb begin
        w_accept     = r_read & ~avm_waitrequest;
        w_stall      = r_read & avm_waitrequest;
        w_stall_next = {1'b0, r_stall} + cnt_ext_t'(1);
        timeout      = w_stall && (w_stall_next == LP_TIMEOUT);
        rd_valid     = (LP_LAT == 2'd0) ? w_accept : (r_lat == 2'd1);
        rd_data      = avm_readdata;
        avm_read     = r_read;
        avm_address  = r_addr;
    end

    // Request register, stall counter and latency countdown
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_read  <= 1'b0;
            r_addr  <= ADDR_ID;
            r_stall <= '0;
            r_lat   <= '0;
        end else begin
            // go is ignored while a read is outstanding, which leaves one idle
            // bus cycle between consecutive words
            if (r_read) begin
                if (w_accept || timeout) begin
                    r_read <= 1'b0;
                end
                if (w_stall) begin
                    r_stall <= r_stall + 1'b1;
                end
            end else if (go) begin
                r_read  <= 1'b1;
                r_addr  <= addr;
                r_stall <= '0;
            end
            if (w_accept && (LP_LAT != 2'd0)) begin
                r_lat <= LP_LAT;
            end else if (r_lat != 2'd0) begin
                r_lat <= r_lat - 2'd1;
            end
        end
    end

endmodule

// File: rtl/sysid_read_checker.sv
// Boot-time check of the system-ID slave: reads ID and build timestamp,
// compares them against expected values and reports pass/fail.
module sysid_read_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1518032159,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err,
    output logic        pass
);

    localparam bit LP_ZERO_LAT = (READ_LATENCY == 0);

    state_t      r_state;
    state_t      w_next;
    logic        r_first;
    logic        r_done;
    logic        r_id_m;
    logic        r_ts_m;
    logic        r_to;
    logic [31:0] r_id;
    logic [31:0] r_ts;

    logic        w_go;
    logic        w_addr;
    logic        w_accept;
    logic        w_rd_valid;
    logic [31:0] w_rd_data;
    logic        w_timeout;
    logic        w_start_seq;
    logic        w_cap_id;
    logic        w_cap_ts;

    avm_single_read #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd (
        .clock           (clock),
        .reset_n         (reset_n),
        .go              (w_go),
        .addr            (w_addr),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .rd_valid        (w_rd_valid),
        .rd_data         (w_rd_data),
        .timeout         (w_timeout)
    );

    // Next-state, capture strobes and read-engine requests
    always_comb begin
        w_next      = r_state;
        w_start_seq = 1'b0;
        w_cap_id    = 1'b0;
        w_cap_ts    = 1'b0;
        w_accept    = avm_read & ~avm_waitrequest;
        case (r_state)
            S_IDLE: begin
                // The first clock after reset belongs to AUTO_START alone
                if (r_first) begin
                    w_start_seq = AUTO_START;
                end else begin
                    w_start_seq = start;
                end
                if (w_start_seq) begin
                    w_next = S_REQ_ID;
                end
            end
            S_REQ_ID: begin
                if (w_timeout) begin
                    w_next = S_DONE;
                end else if (w_accept) begin
                    if (LP_ZERO_LAT) begin
                        w_cap_id = 1'b1;
                        w_next   = S_REQ_TS;
                    end else begin
                        w_next   = S_LAT_ID;
                    end
                end
            end
            S_LAT_ID: begin
                if (w_rd_valid) begin
                    w_cap_id = 1'b1;
                    w_next   = S_REQ_TS;
                end
            end
            S_REQ_TS: begin
                if (w_timeout) begin
                    w_next = S_DONE;
                end else if (w_accept) begin
                    if (LP_ZERO_LAT) begin
                        w_cap_ts = 1'b1;
                        w_next   = S_DONE;
                    end else begin
                        w_next   = S_LAT_TS;
                    end
                end
            end
            S_LAT_TS: begin
                if (w_rd_valid) begin
                    w_cap_ts = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                w_start_seq = start;
                if (start) begin
                    w_next = S_REQ_ID;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Request is raised one edge ahead so avm_read aligns with the REQ state
        w_go   = (w_next == S_REQ_ID) || (w_next == S_REQ_TS);
        w_addr = (w_next == S_REQ_TS) ? ADDR_TS : ADDR_ID;
    end

    // State register and result capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_first <= 1'b1;
            r_done  <= 1'b0;
            r_id    <= '0;
            r_ts    <= '0;
            r_id_m  <= 1'b0;
            r_ts_m  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= 1'b0;
            if (w_start_seq) begin
                r_done <= 1'b0;
                r_id   <= '0;
                r_ts   <= '0;
                r_id_m <= 1'b0;
                r_ts_m <= 1'b0;
                r_to   <= 1'b0;
            end
            if (w_cap_id) begin
                r_id   <= w_rd_data;
                r_id_m <= (w_rd_data == EXPECTED_ID);
            end
            if (w_cap_ts) begin
                r_ts   <= w_rd_data;
                r_ts_m <= (w_rd_data == EXPECTED_TS);
            end
            if (w_timeout) begin
                r_to <= 1'b1;
            end
            if ((w_next == S_DONE) && (r_state != S_DONE)) begin
                r_done <= 1'b1;
            end
        end
    end

    // Status outputs
    always_comb begin
        busy        = (r_state != S_IDLE) && (r_state != S_DONE);
        done        = r_done;
        id_value    = r_id;
        ts_value    = r_ts;
        id_match    = r_id_m;
        ts_match    = r_ts_m;
        timeout_err = r_to;
        pass        = r_done & r_id_m & r_ts_m & ~r_to;
    end

endmodule

// File: tb/tb_sysid_read_checker.sv
// Directed bench for sysid_read_checker: a zero-latency instance with a
// stall-capable slave, and a READ_LATENCY=2 instance with a pipelined slave.
module tb_sysid_read_checker;

    localparam logic [31:0] TS_GOOD = 32'd1518032159;
    localparam logic [31:0] TS_BAD  = 32'h1234_5678;
    localparam logic [31:0] JUNK    = 32'hBAD0_0BAD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // Slave model controls
    int   stall_cfg = 0;
    logic stuck     = 1'b0;
    int   stall_cnt = 0;
    int   acc_id    = 0;
    int   acc_ts    = 0;

    logic [31:0] mem_a [2];
    logic [31:0] mem_b [2];

    // DUT A signals (READ_LATENCY=0)
    logic        a_addr, a_read, a_ws, a_busy, a_done, a_idm, a_tsm, a_to, a_pass;
    logic [31:0] a_rdata, a_id, a_ts;
    logic [71:0] a_outs;

    // DUT B signals (READ_LATENCY=2)
    logic        b_addr, b_read, b_ws, b_busy, b_done, b_idm, b_tsm, b_to, b_pass;
    logic [31:0] b_rdata, b_id, b_ts;
    logic [71:0] b_outs;
    logic        b_p1_v = 1'b0, b_p2_v = 1'b0, b_p1_a = 1'b0, b_p2_a = 1'b0;

    always #5 clk = ~clk;

    sysid_read_checker #(
        .EXPECTED_ID(32'd0), .EXPECTED_TS(TS_GOOD), .READ_LATENCY(0),
        .TIMEOUT_CYCLES(8), .AUTO_START(1'b1)
    ) dut_a (
        .clock(clk), .reset_n(rst_n), .start(start),
        .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_ws),
        .avm_readdata(a_rdata), .busy(a_busy), .done(a_done),
        .id_value(a_id), .ts_value(a_ts), .id_match(a_idm), .ts_match(a_tsm),
        .timeout_err(a_to), .pass(a_pass)
    );

    sysid_read_checker #(
        .EXPECTED_ID(32'd0), .EXPECTED_TS(TS_GOOD), .READ_LATENCY(2),
        .TIMEOUT_CYCLES(8), .AUTO_START(1'b1)
    ) dut_b (
        .clock(clk), .reset_n(rst_n), .start(start),
        .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(b_ws),
        .avm_readdata(b_rdata), .busy(b_busy), .done(b_done),
        .id_value(b_id), .ts_value(b_ts), .id_match(b_idm), .ts_match(b_tsm),
        .timeout_err(b_to), .pass(b_pass)
    );

    assign a_outs = {a_addr, a_read, a_busy, a_done, a_id, a_ts, a_idm, a_tsm, a_to, a_pass};
    assign b_outs = {b_addr, b_read, b_busy, b_done, b_id, b_ts, b_idm, b_tsm, b_to, b_pass};

    // Slave A: optional waitrequest stalls, data valid only in the accept cycle
    always_comb begin
        if (stuck) a_ws = 1'b1;
        else       a_ws = a_read && (stall_cnt < stall_cfg);
        a_rdata = (a_read && !a_ws) ? mem_a[a_addr] : JUNK;
    end

    // Slave B: never stalls, data appears two cycles after accept
    always_comb begin
        b_ws    = 1'b0;
        b_rdata = b_p2_v ? mem_b[b_p2_a] : JUNK;
    end

    always @(posedge clk) begin
        if (a_read && a_ws) stall_cnt <= stall_cnt + 1;
        else                stall_cnt <= 0;
        if (a_read && !a_ws) begin
            if (a_addr) acc_ts <= acc_ts + 1;
            else        acc_id <= acc_id + 1;
        end
        b_p1_v <= b_read && !b_ws;
        b_p1_a <= b_addr;
        b_p2_v <= b_p1_v;
        b_p2_a <= b_p1_a;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (a_outs !== 72'd0) begin
            miscompares++; $display("FAIL reset_a_outputs: got %h expected 0", a_outs);
        end
        vectors++;
        if (b_outs !== 72'd0) begin
            miscompares++; $display("FAIL reset_b_outputs: got %h expected 0", b_outs);
        end
        rst_n = 1'b1;
    endtask

    // Zero-wait auto-start on A (done at cycle 4); latency-2 wrong TS on B (done at 7)
    task automatic test_auto_start();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 3) begin
                vectors++;
                if (a_done !== 1'b0) begin
                    miscompares++; $display("FAIL auto_done_early: got %b expected 0", a_done);
                end
            end
            if (c == 4) begin
                vectors++;
                if ({a_done, a_pass, a_busy} !== 3'b110) begin
                    miscompares++; $display("FAIL auto_done_pass_busy: got %b expected 110", {a_done, a_pass, a_busy});
                end
                vectors++;
                if (a_ts !== TS_GOOD || a_id !== 32'd0) begin
                    miscompares++; $display("FAIL auto_values: got %h/%h expected 0/%h", a_id, a_ts, TS_GOOD);
                end
            end
            if (c == 6) begin
                vectors++;
                if (b_done !== 1'b0) begin
                    miscompares++; $display("FAIL lat2_done_early: got %b expected 0", b_done);
                end
            end
            if (c == 7) begin
                vectors++;
                if (b_ts !== TS_BAD || b_id !== 32'd0) begin
                    miscompares++; $display("FAIL lat2_values: got %h/%h expected 0/%h", b_id, b_ts, TS_BAD);
                end
                vectors++;
                if ({b_done, b_idm, b_tsm, b_pass} !== 4'b1100) begin
                    miscompares++; $display("FAIL lat2_flags: got %b expected 1100", {b_done, b_idm, b_tsm, b_pass});
                end
            end
        end
    endtask

    task automatic test_stall();
        int   id0 = acc_id;
        int   ts0 = acc_ts;
        logic prev_stall = 1'b0;
        logic prev_addr  = 1'b0;
        stall_cfg = 3;
        start     = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (prev_stall) begin
                vectors++;
                if (a_read !== 1'b1 || a_addr !== prev_addr) begin
                    miscompares++; $display("FAIL stall_hold c%0d: got read=%b addr=%b expected read=1 addr=%b", c, a_read, a_addr, prev_addr);
                end
            end
            prev_stall = a_read && a_ws;
            prev_addr  = a_addr;
            if (c == 9) begin
                vectors++;
                if (a_done !== 1'b0) begin
                    miscompares++; $display("FAIL stall_done_early: got %b expected 0", a_done);
                end
            end
            if (c == 10) begin
                vectors++;
                if ({a_done, a_pass} !== 2'b11) begin
                    miscompares++; $display("FAIL stall_done_pass: got %b expected 11", {a_done, a_pass});
                end
            end
        end
        vectors++;
        if (acc_id - id0 != 1 || acc_ts - ts0 != 1) begin
            miscompares++; $display("FAIL stall_accepts: got id=%0d ts=%0d expected 1/1", acc_id - id0, acc_ts - ts0);
        end
    endtask

    task automatic test_busy_start();
        int id0 = acc_id;
        stall_cfg = 3;
        start     = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 6) start = 1'b1;
            if (c == 7) begin
                start = 1'b0;
                vectors++;
                if ({a_read, a_addr, a_busy} !== 3'b111) begin
                    miscompares++; $display("FAIL busy_start_req_ts: got %b expected 111", {a_read, a_addr, a_busy});
                end
            end
            if (c == 10) begin
                vectors++;
                if ({a_done, a_pass, a_busy} !== 3'b110 || a_id !== 32'd0) begin
                    miscompares++; $display("FAIL busy_start_done: got %b id=%h expected 110 id=0", {a_done, a_pass, a_busy}, a_id);
                end
            end
        end
        vectors++;
        if (acc_id - id0 != 1) begin
            miscompares++; $display("FAIL busy_start_id_accepts: got %0d expected 1", acc_id - id0);
        end
    endtask

    task automatic test_timeout();
        int ts0 = acc_ts;
        stuck = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c <= 8) begin
                vectors++;
                if (a_read !== 1'b1 || a_addr !== 1'b0) begin
                    miscompares++; $display("FAIL timeout_hold c%0d: got read=%b addr=%b expected 1/0", c, a_read, a_addr);
                end
            end else begin
                vectors++;
                if (a_read !== 1'b0) begin
                    miscompares++; $display("FAIL timeout_read_low c%0d: got %b expected 0", c, a_read);
                end
            end
            if (c == 9) begin
                vectors++;
                if ({a_to, a_done, a_pass, a_busy} !== 4'b1100) begin
                    miscompares++; $display("FAIL timeout_flags: got %b expected 1100", {a_to, a_done, a_pass, a_busy});
                end
            end
        end
        vectors++;
        if (acc_ts - ts0 != 0 || a_ts !== 32'd0 || a_tsm !== 1'b0 || a_idm !== 1'b0) begin
            miscompares++; $display("FAIL timeout_no_ts: got accepts=%0d ts=%h tsm=%b idm=%b expected 0/0/0/0", acc_ts - ts0, a_ts, a_tsm, a_idm);
        end
        stuck = 1'b0;
    endtask

    task automatic test_restart();
        stall_cfg = 0;
        start     = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                vectors++;
                if ({a_done, a_to, a_busy} !== 3'b001 || a_ts !== 32'd0) begin
                    miscompares++; $display("FAIL restart_clear: got %b ts=%h expected 001 ts=0", {a_done, a_to, a_busy}, a_ts);
                end
            end
            if (c == 3) begin
                vectors++;
                if (a_done !== 1'b0) begin
                    miscompares++; $display("FAIL restart_done_early: got %b expected 0", a_done);
                end
            end
            if (c == 4) begin
                vectors++;
                if ({a_done, a_idm, a_tsm, a_pass} !== 4'b1111 || a_ts !== TS_GOOD) begin
                    miscompares++; $display("FAIL restart_result: got %b ts=%h expected 1111 ts=%h", {a_done, a_idm, a_tsm, a_pass}, a_ts, TS_GOOD);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        stall_cfg = 3;
        start     = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        vectors++;
        if ({a_read, a_addr} !== 2'b11) begin
            miscompares++; $display("FAIL abort_pre_req_ts: got %b expected 11", {a_read, a_addr});
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_outs !== 72'd0) begin
            miscompares++; $display("FAIL abort_async_clear: got %h expected 0", a_outs);
        end
        @(negedge clk);
        stall_cfg = 0;
        rst_n     = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) begin
                vectors++;
                if ({a_done, a_pass} !== 2'b11 || a_ts !== TS_GOOD) begin
                    miscompares++; $display("FAIL abort_rerun: got %b ts=%h expected 11 ts=%h", {a_done, a_pass}, a_ts, TS_GOOD);
                end
            end
        end
    endtask

    initial begin
        mem_a[0] = 32'd0;
        mem_a[1] = TS_GOOD;
        mem_b[0] = 32'd0;
        mem_b[1] = TS_BAD;
        test_reset();
        test_auto_start();
        test_stall();
        test_busy_start();
        test_timeout();
        test_restart();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
